systolic_edge_rx: RTL and testbench

//  Receiver for the nibble-serial edge stream leaving a systolic tile chain (row_out/col_out + ctrl).

---
 rtl/systolic_edge_rx.sv | 191 +++++++++++++++++++
 tb/tb_systolic_edge_rx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_edge_rx.sv
// systolic_edge_rx
//   Receiver for the nibble-serial edge stream leaving a systolic tile chain.
//   Nibbles arrive MSB nibble first, framed by a start strobe on the first
//   nibble. They are reassembled into 4*NIBBLES-bit words and queued in a small
//   FIFO that the consumer drains through a valid/ready handshake.
//
// Parameters
//   NIBBLES     data nibbles per word (1..8), word width W = 4*NIBBLES
//   FIFO_DEPTH  word FIFO entries, power of two (2..16)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   ena         beat enable; when low the assembler holds its state
//   nib_in      serial data nibble
//   ctrl_in     frame-start strobe, high on the first nibble of a frame
//   word_out    FIFO head word, forced to zero while the FIFO is empty
//   word_valid  FIFO not empty
//   word_ready  consumer accepts the head word when word_valid is high
//   overflow    sticky flag: a completed word was dropped on a full FIFO
//   frame_err   one-cycle pulse: a frame restarted before completing
//   parity_err  one-cycle pulse: trailing parity nibble mismatched
//               (present only with the parity option)
//   level       FIFO occupancy, 0..FIFO_DEPTH
//
// Configuration
//   SYSTOLIC_EDGE_RX_PARITY_EN: each frame carries one extra trailing nibble,
//   the XOR of all data nibbles. Words failing the check are not queued.

module systolic_edge_rx #(
  parameter int NIBBLES    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [3:0]           nib_in,
  input  logic                 ctrl_in,
  output logic [4*NIBBLES-1:0] word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 overflow,
  output logic                 frame_err,
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic [4:0]           level
);

  localparam int W  = 4 * NIBBLES;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
  localparam int FRAME_LEN = NIBBLES + 1;
`else
  localparam int FRAME_LEN = NIBBLES;
`endif

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic [W-1:0]   asm_q;
  logic           frame_err_q;
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
  logic [3:0]     par_q;
  logic           parity_err_q;
  logic           parity_ok;
`endif

  logic [W-1:0]   asm_shift;
  logic [W-1:0]   asm_start;
  logic [W-1:0]   done_word;
  logic           frame_done;
  logic           push_ok;

  logic [W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [4:0]     level_q, level_d;
  logic           overflow_q;
  logic           pop, full, wr_en;

  // Frame completion detection and the word that completes on this beat.
  // The concatenation is truncated so the oldest nibble falls off the top,
  // which also keeps the expression legal when NIBBLES is 1.
  always_comb begin
    asm_shift      = W'({asm_q, nib_in});
    asm_start      = '0;
    asm_start[3:0] = nib_in;
    frame_done     = 1'b0;
    done_word      = asm_shift;
    if (ena) begin
      if (ctrl_in) begin
        frame_done = (FRAME_LEN == 1);
        done_word  = asm_start;
      end else if (state_q == COLLECT) begin
        frame_done = (int'(cnt_q) + 1 == FRAME_LEN);
      end
    end
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
    // The last beat carries parity, so the data word is already in asm_q.
    done_word = asm_q;
    parity_ok = (par_q == nib_in);
    push_ok   = frame_done & parity_ok;
`else
    push_ok   = frame_done;
`endif
  end

  // Assembler FSM: a start strobe always opens a new frame, flagging an
  // error when it cuts a partial frame short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      asm_q        <= '0;
      frame_err_q  <= 1'b0;
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
      par_q        <= '0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (ena) begin
        if (ctrl_in) begin
          frame_err_q <= (state_q == COLLECT);
          asm_q       <= asm_start;
          cnt_q       <= frame_done ? 4'd0 : 4'd1;
          state_q     <= frame_done ? IDLE : COLLECT;
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
          par_q       <= nib_in;
`endif
        end else if (state_q == COLLECT) begin
          if (frame_done) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
            parity_err_q <= ~parity_ok;
`endif
          end else begin
            asm_q <= asm_shift;
            cnt_q <= cnt_q + 4'd1;
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
            par_q <= par_q ^ nib_in;
`endif
          end
        end
      end
    end
  end

  // A full FIFO still accepts a push when the head is popped on the same edge.
  always_comb begin
    pop     = (level_q != 5'd0) & word_ready;
    full    = (level_q == 5'(FIFO_DEPTH));
    wr_en   = push_ok & (~full | pop);
    level_d = level_q + 5'(wr_en) - 5'(pop);
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (pop)   rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      if (push_ok & full & ~pop) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: word_out is gated by occupancy.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= done_word;
  end

  assign word_valid = (level_q != 5'd0);
  assign word_out   = word_valid ? mem_q[rptr_q] : '0;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_systolic_edge_rx.sv
// tb_systolic_edge_rx
//   Directed and randomized checks of systolic_edge_rx against a queue-based
//   reference model: a frame is a list of nibbles, the FIFO is a list of words.

module tb_systolic_edge_rx;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int W     = 4 * N;
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
  localparam int FLEN = N + 1;
`else
  localparam int FLEN = N;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [3:0]   nib_in;
  logic         ctrl_in;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready;
  logic         overflow;
  logic         frame_err;
  logic [4:0]   level;
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
  logic         parity_err;
`endif

  int assertsEvaluated = 0;
  int failures = 0;

  logic [3:0]   frameQ[$];
  bit           inFrame;
  logic [W-1:0] fifoQ[$];
  bit           expOverflow;
  bit           expFrameErr;
  bit           expParityErr;

  systolic_edge_rx #(.NIBBLES(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .nib_in     (nib_in),
    .ctrl_in    (ctrl_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .frame_err  (frame_err),
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertsEvaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".valid"}, 32'(word_valid), 32'(fifoQ.size() != 0));
    checkOutput({tag, ".level"}, 32'(level), 32'(fifoQ.size()));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(expOverflow));
    checkOutput({tag, ".frame_err"}, 32'(frame_err), 32'(expFrameErr));
    if (fifoQ.size() != 0)
      checkOutput({tag, ".word"}, 32'(word_out), 32'(fifoQ[0]));
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
    checkOutput({tag, ".parity_err"}, 32'(parity_err), 32'(expParityErr));
`endif
  endtask

  task automatic modelReset();
    frameQ.delete();
    fifoQ.delete();
    inFrame      = 0;
    expOverflow  = 0;
    expFrameErr  = 0;
    expParityErr = 0;
  endtask

  // One clock edge: drive inputs, advance the model, then check after the edge.
  task automatic applyStimulus(input bit e, input logic [3:0] n, input bit c, input bit r, input string tag);
    bit           doPop;
    bit           doPush;
    logic [W-1:0] w;
    int           x;
    ena = e; nib_in = n; ctrl_in = c; word_ready = r;
    doPop = (fifoQ.size() != 0) && r;
    doPush = 0;
    w = '0;
    expFrameErr  = 0;
    expParityErr = 0;
    if (e) begin
      if (c) begin
        expFrameErr = inFrame;
        frameQ.delete();
        frameQ.push_back(n);
        inFrame = 1;
      end else if (inFrame) begin
        frameQ.push_back(n);
      end
      if (inFrame && frameQ.size() == FLEN) begin
        for (int i = 0; i < N; i++) w = w * 16 + W'(frameQ[i]);
        doPush = 1;
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
        x = 0;
        for (int i = 0; i < N; i++) x = x ^ int'(frameQ[i]);
        if (x != int'(frameQ[N])) begin
          doPush = 0;
          expParityErr = 1;
        end
`else
        x = 0;
`endif
        frameQ.delete();
        inFrame = 0;
      end
    end
    if (doPop) void'(fifoQ.pop_front());
    if (doPush) begin
      if (fifoQ.size() < DEPTH) fifoQ.push_back(w);
      else expOverflow = 1;
    end
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  // Sends a complete frame, with correct trailing parity when enabled.
  task automatic sendWord(input logic [W-1:0] word, input bit r, input string tag);
    logic [3:0] p;
    logic [3:0] nib;
    p = '0;
    for (int i = 0; i < N; i++) begin
      nib = word[(N-1-i)*4 +: 4];
      p = p ^ nib;
      applyStimulus(1'b1, nib, i == 0, r, tag);
    end
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
    applyStimulus(1'b1, p, 1'b0, r, tag);
`endif
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, tag);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("reset");
    checkOutput("reset.word_out", 32'(word_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    ena = 0; nib_in = 0; ctrl_in = 0; word_ready = 0;
    modelReset();
    doReset();

    // Basic frame assembly and single-edge latency.
    sendWord(16'hABCD, 1'b0, "t1");
    checkOutput("t1.word_abcd", 32'(word_out), 32'h0000ABCD);
    checkOutput("t1.level1", 32'(level), 32'd1);
    drain("t1.drain");

    // Enable stall between the second and third nibble.
    applyStimulus(1'b1, 4'h1, 1'b1, 1'b0, "t2");
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0, "t2");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'hF, 1'b1, 1'b0, "t2.stall");
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0, "t2");
    applyStimulus(1'b1, 4'h4, 1'b0, 1'b0, "t2");
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
    applyStimulus(1'b1, 4'h4, 1'b0, 1'b0, "t2.par");
`endif
    checkOutput("t2.word_1234", 32'(word_out), 32'h00001234);
    drain("t2.drain");

    // Restart after two nibbles.
    applyStimulus(1'b1, 4'h5, 1'b1, 1'b0, "t3");
    applyStimulus(1'b1, 4'h6, 1'b0, 1'b0, "t3");
    applyStimulus(1'b1, 4'h7, 1'b1, 1'b0, "t3.restart");
    checkOutput("t3.frame_err_pulse", 32'(frame_err), 32'd1);
    applyStimulus(1'b1, 4'h8, 1'b0, 1'b0, "t3");
    applyStimulus(1'b1, 4'h9, 1'b0, 1'b0, "t3");
    applyStimulus(1'b1, 4'hA, 1'b0, 1'b0, "t3");
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
    applyStimulus(1'b1, 4'h7 ^ 4'h8 ^ 4'h9 ^ 4'hA, 1'b0, 1'b0, "t3.par");
`endif
    checkOutput("t3.word_789a", 32'(word_out), 32'h0000789A);
    checkOutput("t3.level1", 32'(level), 32'd1);
    drain("t3.drain");

    // Overflow with the consumer stalled; the first four words survive in order.
    for (int i = 0; i < 5; i++) sendWord(W'(16'h1111 * (i + 1)), 1'b0, "t4");
    checkOutput("t4.level_full", 32'(level), 32'd4);
    checkOutput("t4.overflow", 32'(overflow), 32'd1);
    checkOutput("t4.head", 32'(word_out), 32'h00001111);
    drain("t4.drain");

    // Full FIFO with a pop on the completing edge: no overflow.
    doReset();
    for (int i = 0; i < 4; i++) sendWord(W'(16'hC0DE + i), 1'b0, "t5.fill");
    applyStimulus(1'b1, 4'hF, 1'b1, 1'b0, "t5");
    applyStimulus(1'b1, 4'hE, 1'b0, 1'b0, "t5");
    applyStimulus(1'b1, 4'hD, 1'b0, 1'b0, "t5");
`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
    applyStimulus(1'b1, 4'hC, 1'b0, 1'b0, "t5");
    applyStimulus(1'b1, 4'hF ^ 4'hE ^ 4'hD ^ 4'hC, 1'b0, 1'b1, "t5.last");
`else
    applyStimulus(1'b1, 4'hC, 1'b0, 1'b1, "t5.last");
`endif
    checkOutput("t5.no_overflow", 32'(overflow), 32'd0);
    checkOutput("t5.level_kept", 32'(level), 32'd4);
    drain("t5.drain");

`ifdef SYSTOLIC_EDGE_RX_PARITY_EN
    // Good parity is delivered, bad parity is dropped with a pulse.
    applyStimulus(1'b1, 4'h1, 1'b1, 1'b0, "t6");
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0, "t6");
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0, "t6");
    applyStimulus(1'b1, 4'h4, 1'b0, 1'b0, "t6");
    applyStimulus(1'b1, 4'h4, 1'b0, 1'b0, "t6.good");
    checkOutput("t6.level_good", 32'(level), 32'd1);
    applyStimulus(1'b1, 4'h1, 1'b1, 1'b0, "t6");
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0, "t6");
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0, "t6");
    applyStimulus(1'b1, 4'h4, 1'b0, 1'b0, "t6");
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0, "t6.bad");
    checkOutput("t6.parity_err", 32'(parity_err), 32'd1);
    checkOutput("t6.level_kept", 32'(level), 32'd1);
    drain("t6.drain");
`endif

    // Randomized traffic: sparse restarts, enable gaps, bursty consumer.
    doReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(3, 0) != 0, 4'($urandom), $urandom_range(5, 0) == 0,
                    $urandom_range(2, 0) == 0, "rand");
    end

    // Asynchronous reset mid-frame with a non-empty FIFO.
    doReset();
    sendWord(16'h5A5A, 1'b0, "t7.fill");
    sendWord(16'hA5A5, 1'b0, "t7.fill");
    applyStimulus(1'b1, 4'h3, 1'b1, 1'b0, "t7.partial");
    applyStimulus(1'b1, 4'h4, 1'b0, 1'b0, "t7.partial");
    checkOutput("t7.level_before", 32'(level), 32'd2);
    doReset();
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0, "t7.after");
    sendWord(16'h0F0F, 1'b1, "t7.after");
    drain("t7.drain");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertsEvaluated, failures);
    $finish;
  end

endmodule
